// File: rtl/vlc_frame_serializer_if.sv
// ============================================================================
// vlc_frame_serializer_if
// ----------------------------------------------------------------------------
// Groups the frame serializer's request, codeword and line-side signals into
// one bundle.
//
// Signals:
//   tx_enable   - start request from the enable control unit
//   data_in     - encoded codeword (DATA_W bits) from the LDPC encoder
//   tx_busy     - serializer is in a frame or in the inter-frame gap
//   tx_complete - one-cycle pulse when the last payload chip has been sent
//   tx_out      - Manchester-coded LED modulator drive
//
// Modports:
//   master - the side that requests frames and watches status (upstream / bench)
//   slave  - the serializer itself
// ============================================================================
interface vlc_frame_serializer_if #(
    parameter int DATA_W = 36
);
    logic              tx_enable;
    logic [DATA_W-1:0] data_in;
    logic              tx_busy;
    logic              tx_complete;
    logic              tx_out;

    modport master (
        output tx_enable,
        output data_in,
        input  tx_busy,
        input  tx_complete,
        input  tx_out
    );

    modport slave (
        input  tx_enable,
        input  data_in,
        output tx_busy,
        output tx_complete,
        output tx_out
    );
endinterface

// File: rtl/vlc_frame_serializer.sv
// ============================================================================
// vlc_frame_serializer
// ----------------------------------------------------------------------------
// Downstream stage of the LDPC encoder. Takes one codeword per frame, sends
// preamble (1010...), the sync word and then the codeword MSB first, all
// Manchester coded onto the LED modulator line. Bit 1 is sent as a high chip
// followed by a low chip, bit 0 as low then high; each chip lasts CHIP_TICKS
// clocks. After the payload an idle gap of GAP_BITS bit times follows before
// the next request can be accepted.
//
// Ports:
//   clk  - transmitter clock
//   rst  - asynchronous active-high reset
//   bus  - slave side of vlc_frame_serializer_if
//          (tx_enable, data_in in; tx_busy, tx_complete, tx_out out)
//
// All three outputs come straight from flops.
// ============================================================================
module vlc_frame_serializer #(
    parameter int         DATA_W       = 36,
    parameter int         PREAMBLE_LEN = 8,
    parameter logic [7:0] SYNC_WORD    = 8'hD5,
    parameter int         CHIP_TICKS   = 4,
    parameter int         GAP_BITS     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    vlc_frame_serializer_if.slave   bus
);

    // Counter sizing. The tick counter needs at least one bit even when a
    // chip is a single clock long.
    localparam int TICK_W   = (CHIP_TICKS > 1) ? $clog2(CHIP_TICKS) : 1;
    localparam int MAX_A    = (PREAMBLE_LEN > 8) ? PREAMBLE_LEN : 8;
    localparam int MAX_B    = (DATA_W > GAP_BITS) ? DATA_W : GAP_BITS;
    localparam int MAX_BITS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int BIT_W    = $clog2(MAX_BITS + 1);

    // Terminal counts for each phase.
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CHIP_TICKS - 1);
    localparam logic [BIT_W-1:0]  PRE_LAST  = BIT_W'(PREAMBLE_LEN - 1);
    localparam logic [BIT_W-1:0]  SYNC_LAST = BIT_W'(7);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  GAP_LAST  = BIT_W'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        PAYLOAD,
        GAP
    } state_t;

    // Current state and counters.
    state_t              state;
    logic [TICK_W-1:0]   tick_cnt;
    logic                half_sel;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shift_reg;
    logic                armed;

    // Output flops.
    logic                tx_out_q;
    logic                tx_busy_q;
    logic                tx_complete_q;

    // Next values.
    state_t              state_n;
    logic [TICK_W-1:0]   tick_n;
    logic                half_n;
    logic [BIT_W-1:0]    bit_n;
    logic [DATA_W-1:0]   shift_n;
    logic                out_n;
    logic                busy_n;
    logic                complete_n;

    // Helpers for the next-state logic.
    logic                chip_end;
    logic [BIT_W-1:0]    bit_last;
    state_t              phase_after;

    // Helpers for the output logic.
    logic                bit_val;
    logic [2:0]          sync_idx;

    // ------------------------------------------------------------------------
    // State register. The counters, shift register and output flops all
    // update together, so tx_out always shows the chip addressed by the
    // counters that are loaded at the same edge. 'armed' blocks a capture at
    // the first edge after reset release, so a tx_enable that is already
    // high when rst falls is not taken until the following edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            half_sel      <= 1'b0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            armed         <= 1'b0;
            tx_out_q      <= 1'b0;
            tx_busy_q     <= 1'b0;
            tx_complete_q <= 1'b0;
        end else begin
            state         <= state_n;
            tick_cnt      <= tick_n;
            half_sel      <= half_n;
            bit_cnt       <= bit_n;
            shift_reg     <= shift_n;
            armed         <= 1'b1;
            tx_out_q      <= out_n;
            tx_busy_q     <= busy_n;
            tx_complete_q <= complete_n;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. The phases that carry bits (and the gap, which is
    // just a number of silent bit times) share one chip/half/bit counter
    // chain. The bit counter reloads to zero whenever the phase changes, and
    // the payload shifts once at every payload bit boundary so its MSB is
    // always the bit on the line.
    // ------------------------------------------------------------------------
    always_comb begin
        state_n     = state;
        tick_n      = tick_cnt;
        half_n      = half_sel;
        bit_n       = bit_cnt;
        shift_n     = shift_reg;
        chip_end    = (tick_cnt == TICK_LAST);
        bit_last    = '0;
        phase_after = IDLE;

        case (state)
            PREAMBLE: begin
                bit_last    = PRE_LAST;
                phase_after = SYNC;
            end
            SYNC: begin
                bit_last    = SYNC_LAST;
                phase_after = PAYLOAD;
            end
            PAYLOAD: begin
                bit_last    = DATA_LAST;
                phase_after = GAP;
            end
            GAP: begin
                bit_last    = GAP_LAST;
                phase_after = IDLE;
            end
            default: begin
                bit_last    = '0;
                phase_after = IDLE;
            end
        endcase

        if (state == IDLE) begin
            if (armed && bus.tx_enable) begin
                state_n = PREAMBLE;
                shift_n = bus.data_in;
                tick_n  = '0;
                half_n  = 1'b0;
                bit_n   = '0;
            end
        end else if (!chip_end) begin
            tick_n = tick_cnt + 1'b1;
        end else begin
            tick_n = '0;
            half_n = ~half_sel;
            if (half_sel) begin
                half_n = 1'b0;
                if (state == PAYLOAD) begin
                    shift_n = shift_reg << 1;
                end
                if (bit_cnt == bit_last) begin
                    bit_n   = '0;
                    state_n = phase_after;
                end else begin
                    bit_n = bit_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output logic. Works from the next-state values so that the registered
    // line level matches the chip the counters point at after the edge. A
    // chip is the bit value on the first half and its inverse on the second.
    // The completion pulse marks the PAYLOAD -> GAP step only, so a frame cut
    // short by reset never produces it.
    // ------------------------------------------------------------------------
    always_comb begin
        bit_val  = 1'b0;
        sync_idx = 3'd7 - bit_n[2:0];
        out_n    = 1'b0;

        case (state_n)
            PREAMBLE: bit_val = ~bit_n[0];
            SYNC:     bit_val = SYNC_WORD[sync_idx];
            PAYLOAD:  bit_val = shift_n[DATA_W-1];
            default:  bit_val = 1'b0;
        endcase

        if ((state_n == PREAMBLE) || (state_n == SYNC) || (state_n == PAYLOAD)) begin
            out_n = bit_val ^ half_n;
        end

        busy_n     = (state_n != IDLE);
        complete_n = (state == PAYLOAD) && (state_n == GAP);
    end

    assign bus.tx_out      = tx_out_q;
    assign bus.tx_busy     = tx_busy_q;
    assign bus.tx_complete = tx_complete_q;

endmodule

// File: tb/tb_vlc_frame_serializer.sv
// ============================================================================
// tb_vlc_frame_serializer
// ----------------------------------------------------------------------------
// Bench for vlc_frame_serializer. Two instances share the clock and reset:
// dut_a with default parameters and dut_b with CHIP_TICKS=1, PREAMBLE_LEN=4,
// GAP_BITS=1. Expected line levels come from a frame model that builds the
// bit sequence (preamble, sync word, payload) and Manchester-codes it with
// plain arithmetic on the cycle offset from the capture edge.
// ============================================================================
module tb_vlc_frame_serializer;

    localparam int DW = 36;

    logic clk = 1'b0;
    logic rst;

    int errors = 0;
    int checks = 0;

    vlc_frame_serializer_if #(.DATA_W(DW)) bus_a ();
    vlc_frame_serializer_if #(.DATA_W(DW)) bus_b ();

    vlc_frame_serializer #(
        .DATA_W       (DW),
        .PREAMBLE_LEN (8),
        .SYNC_WORD    (8'hD5),
        .CHIP_TICKS   (4),
        .GAP_BITS     (4)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    vlc_frame_serializer #(
        .DATA_W       (DW),
        .PREAMBLE_LEN (4),
        .SYNC_WORD    (8'hD5),
        .CHIP_TICKS   (1),
        .GAP_BITS     (1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    // One comparison point.
    task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive request and codeword of one instance.
    task automatic apply_stimulus(input bit sel, input logic en, input logic [DW-1:0] data);
        if (sel) begin
            bus_b.tx_enable = en;
            bus_b.data_in   = data;
        end else begin
            bus_a.tx_enable = en;
            bus_a.data_in   = data;
        end
    endtask

    // Expected outputs j cycles after the capture edge of the first of nfr
    // back-to-back frames (p0 then p1). Frame period is frame + gap + one
    // IDLE cycle; past the last frame the line is idle.
    function automatic void model(input int j, input int ct, input int pl, input int gb,
                                  input int nfr, input logic [DW-1:0] p0, input logic [DW-1:0] p1,
                                  output logic eo, output logic eb, output logic ec);
        int fc, gc, per, f, r, c, bi;
        logic [7:0]    sw;
        logic [DW-1:0] pay;
        logic          bv;
        sw  = 8'hD5;
        fc  = (pl + 8 + DW) * 2 * ct;
        gc  = gb * 2 * ct;
        per = fc + gc + 1;
        eo  = 1'b0;
        eb  = 1'b0;
        ec  = 1'b0;
        f   = j / per;
        r   = j % per;
        if (f < nfr) begin
            pay = (f == 0) ? p0 : p1;
            if (r < fc) begin
                c  = r / ct;
                bi = c / 2;
                if (bi < pl)
                    bv = (bi % 2 == 0);
                else if (bi < pl + 8)
                    bv = sw[3'(7 - (bi - pl))];
                else
                    bv = pay[6'(DW - 1 - (bi - pl - 8))];
                eo = (c % 2 == 0) ? bv : ~bv;
                eb = 1'b1;
            end else if (r < fc + gc) begin
                eb = 1'b1;
                ec = (r == fc);
            end
        end
    endfunction

    // Runs ncyc cycles starting with the capture edge (caller has already
    // raised tx_enable), comparing every cycle against the model. tx_enable
    // drops after cycle drop_at; data_in changes to chg_val after chg_at.
    task automatic run_frames(input string tag, input bit sel, input int ct, input int pl,
                              input int gb, input int nfr, input int ncyc, input int drop_at,
                              input int chg_at, input logic [DW-1:0] p0, input logic [DW-1:0] p1,
                              input logic [DW-1:0] chg_val);
        logic eo, eb, ec;
        for (int j = 0; j < ncyc; j++) begin
            @(posedge clk);
            @(negedge clk);
            model(j, ct, pl, gb, nfr, p0, p1, eo, eb, ec);
            if (sel) begin
                check_output($sformatf("%s j=%0d tx_out", tag, j), DW'(bus_b.tx_out), DW'(eo));
                check_output($sformatf("%s j=%0d tx_busy", tag, j), DW'(bus_b.tx_busy), DW'(eb));
                check_output($sformatf("%s j=%0d tx_complete", tag, j), DW'(bus_b.tx_complete), DW'(ec));
            end else begin
                check_output($sformatf("%s j=%0d tx_out", tag, j), DW'(bus_a.tx_out), DW'(eo));
                check_output($sformatf("%s j=%0d tx_busy", tag, j), DW'(bus_a.tx_busy), DW'(eb));
                check_output($sformatf("%s j=%0d tx_complete", tag, j), DW'(bus_a.tx_complete), DW'(ec));
            end
            if (j == drop_at) begin
                if (sel) bus_b.tx_enable = 1'b0;
                else     bus_a.tx_enable = 1'b0;
            end
            if (j == chg_at) begin
                if (sel) bus_b.data_in = chg_val;
                else     bus_a.data_in = chg_val;
            end
        end
    endtask

    task automatic check_idle_a(input string tag);
        check_output({tag, " tx_out"}, DW'(bus_a.tx_out), '0);
        check_output({tag, " tx_busy"}, DW'(bus_a.tx_busy), '0);
        check_output({tag, " tx_complete"}, DW'(bus_a.tx_complete), '0);
    endtask

    localparam int PER_A = 449;
    localparam int PER_B = 99;

    initial begin
        logic [DW-1:0] pay;
        logic [DW-1:0] chg;
        int            chg_at;

        // Reset with a request already pending on both instances.
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b1, 36'h9_A5A5_A5A5);
        apply_stimulus(1'b1, 1'b0, 36'h0);
        #1;
        check_idle_a("reset_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_a($sformatf("reset_hold%0d", i));
            check_output($sformatf("reset_hold%0d b_busy", i), DW'(bus_b.tx_busy), '0);
        end

        // Release with tx_enable high: the first edge must not capture.
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_a("release_ignored");

        // Single frame, data_in changed to 0 at k+100.
        $display("[TB] single frame 9_A5A5_A5A5");
        run_frames("single", 1'b0, 4, 8, 4, 1, PER_A + 3, 0, 100,
                   36'h9_A5A5_A5A5, 36'h0, 36'h0);

        // Back-to-back frames with tx_enable held high.
        $display("[TB] back-to-back frames");
        apply_stimulus(1'b0, 1'b1, 36'h1);
        run_frames("b2b", 1'b0, 4, 8, 4, 2, 2 * PER_A, PER_A, 1,
                   36'h1, 36'hF_FFFF_FFFE, 36'hF_FFFF_FFFE);

        // Abort inside PAYLOAD, then a fresh frame.
        $display("[TB] abort mid-frame");
        apply_stimulus(1'b0, 1'b1, 36'h9_A5A5_A5A5);
        run_frames("abort_pre", 1'b0, 4, 8, 4, 1, 300, 0, -1,
                   36'h9_A5A5_A5A5, 36'h0, 36'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b1, 36'h0_0000_0001);
        #1;
        check_idle_a("abort_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_a($sformatf("abort_hold%0d", i));
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_a("abort_release_ignored");
        run_frames("after_abort", 1'b0, 4, 8, 4, 1, PER_A + 3, 0, -1,
                   36'h0_0000_0001, 36'h0, 36'h0);

        // Random payloads with random idle spacing and random mid-frame
        // data_in disturbance.
        for (int n = 0; n < 3; n++) begin
            apply_stimulus(1'b0, 1'b0, '0);
            repeat ($urandom_range(5, 1)) @(negedge clk);
            pay    = {4'($urandom_range(15, 0)), 32'($urandom())};
            chg    = {4'($urandom_range(15, 0)), 32'($urandom())};
            chg_at = int'($urandom_range(400, 1));
            $display("[TB] random frame %0d payload=%0h", n, pay);
            apply_stimulus(1'b0, 1'b1, pay);
            run_frames($sformatf("rand%0d", n), 1'b0, 4, 8, 4, 1, PER_A, 0, chg_at,
                       pay, 36'h0, chg);
        end

        // Parameter sweep instance.
        $display("[TB] sweep CHIP_TICKS=1 PREAMBLE_LEN=4 GAP_BITS=1");
        apply_stimulus(1'b1, 1'b1, 36'h9_A5A5_A5A5);
        run_frames("sweep", 1'b1, 1, 4, 1, 1, PER_B + 3, 0, -1,
                   36'h9_A5A5_A5A5, 36'h0, 36'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vlc_frame_serializer.md
Name: vlc_frame_serializer

Overview:
- Downstream stage of the LDPC encoder. Accepts one 36-bit encoded codeword per frame, prepends a preamble and sync word, Manchester-codes the bitstream and drives the LED modulator line (tx_out).
- Signals frame completion back to the enable control unit through tx_complete.
- Runs on the transmitter clock domain.

Parameters:
- DATA_W, 36, payload (codeword) width in bits; sent MSB first.
- PREAMBLE_LEN, 8, preamble length in bits; pattern 1,0,1,0,... starting with 1.
- SYNC_WORD, 8'hD5, 8-bit start-of-frame delimiter; sent MSB first after the preamble.
- CHIP_TICKS, 4, clock cycles per Manchester half-bit (chip); must be >= 1.
- GAP_BITS, 4, inter-frame idle gap in bit times (gap = GAP_BITS*2*CHIP_TICKS cycles).

Ports:
- clk, input, 1, transmitter clock.
- rst, input, 1, asynchronous active-high reset.
- tx_enable, input, 1, start request; sampled only in IDLE.
- data_in, input, DATA_W, encoded codeword; captured on the accepting edge.
- tx_busy, output, 1, high from PREAMBLE through GAP inclusive.
- tx_complete, output, 1, one-cycle pulse at the end of the last payload chip.
- tx_out, output, 1, Manchester-coded optical drive line; registered.

Behaviour:
- Reset (async assert, values hold while rst=1):
  - state=IDLE; tx_out=0; tx_busy=0; tx_complete=0.
  - All counters and the shift register are cleared.
- Manchester convention:
  - bit 1 -> high chip then low chip.
  - bit 0 -> low chip then high chip.
  - Each chip lasts exactly CHIP_TICKS cycles.
- States: IDLE -> PREAMBLE -> SYNC -> PAYLOAD -> GAP -> IDLE.
- IDLE:
  - tx_out=0, tx_busy=0.
  - If tx_enable=1 at edge k: data_in is latched into the payload shift register and the state becomes PREAMBLE.
  - At that same edge k, tx_out takes the first chip value (1), and tx_busy goes to 1.
- PREAMBLE: PREAMBLE_LEN bits, then SYNC.
- SYNC: 8 bits of SYNC_WORD, then PAYLOAD.
- PAYLOAD: DATA_W bits, MSB first. The shift register shifts once per bit boundary.
- Frame length is (PREAMBLE_LEN+8+DATA_W)*2*CHIP_TICKS cycles; 416 with defaults.
  - tx_out carries frame chips during cycles after edges k .. k+415.
- At edge k+416:
  - state=GAP, tx_out=0, tx_complete=1 for exactly one cycle (cleared at edge k+417).
- GAP:
  - tx_out=0, tx_busy=1 for GAP_BITS*2*CHIP_TICKS cycles (32 with defaults).
  - At edge k+448: state=IDLE, tx_busy=0.
- Back-to-back frames: with tx_enable held high, the next capture occurs at the first IDLE edge (k+449). Minimum frame period is 449 cycles with defaults.
- tx_enable and data_in are ignored outside IDLE. A change on data_in mid-frame does not affect the frame in flight.
- Counters:
  - Chip tick counter, width ceil(log2(CHIP_TICKS)), wraps at CHIP_TICKS-1.
  - Half-select bit toggles per chip.
  - Bit counter sized for max(PREAMBLE_LEN, 8, DATA_W, GAP_BITS); reloads at each state change.
  - No counter overflows or wraps beyond its terminal value.
- Reset mid-frame (any state): immediate return to IDLE with all outputs 0. tx_complete is never pulsed for an aborted frame.
- tx_enable asserted in the same cycle rst deasserts: ignored. The first capture is possible at the following edge.

Test Plan:
- Reset behaviour: assert rst mid-clock with tx_enable=1 -> tx_out, tx_busy, tx_complete all read 0 immediately and stay 0 while rst=1.
- Single frame, data_in=36'h9_A5A5_A5A5, one-cycle tx_enable pulse at edge k:
  - Preamble decodes 10101010, then 11010101 (0xD5), then the payload bits of 36'h9_A5A5_A5A5 MSB first (1001 then 1010 0101 repeated).
  - Every chip is exactly 4 cycles.
  - Exactly one tx_complete pulse, at edge k+416.
  - tx_busy falls at edge k+448.
- Data stability: change data_in to 36'h0 at cycle k+100 -> decoded payload is still 9_A5A5_A5A5.
- Continuous tx_enable=1 with data_in alternating 36'h1 and 36'hF_FFFF_FFFE per frame:
  - Second frame captures at edge k+449.
  - tx_out=0 for the 32-cycle gap.
  - Two tx_complete pulses, 449 cycles apart.
- Abort: assert rst at cycle k+300 (inside PAYLOAD), release, pulse tx_enable with data_in=36'h0_0000_0001:
  - No tx_complete for the aborted frame.
  - The new frame starts from the preamble and completes with the correct payload.
- Parameter sweep CHIP_TICKS=1, PREAMBLE_LEN=4, GAP_BITS=1:
  - Frame length (4+8+36)*2 = 96 cycles; tx_complete at edge k+96.
  - Back in IDLE at edge k+98.
